// File: rtl/spi_arb.sv
// Round-robin arbiter that shares one SPI engine between the A2D (0) and inertial (1) requesters.
// Build macro SPI_ARB_TIMEOUT_EN adds a WAIT timeout that completes the transaction with resp=16'hFFFF.
module spi_arb #(
  parameter int GAP     = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [15:0] cmd0,
  input  logic        req1,
  input  logic [15:0] cmd1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] resp,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        eng_done,
  input  logic [15:0] rd_data,
  output logic        busy,
  output logic [1:0]  o_dbg_state
);

  // Handshake: reqN is a level held until doneN; doneN is a one-cycle pulse, and a
  // reqN still high in IDLE afterwards is a fresh request. wrt/eng_done are single pulses.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

  localparam int GW = $clog2(GAP + 1);

  state_t        r_state;
  state_t        w_next;
  logic [GW-1:0] r_gap_cnt;
  logic          r_last;
  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_done0;
  logic          r_done1;
  logic [15:0]   r_cmd;
  logic [15:0]   r_resp;
  logic          w_pick1;
  logic          w_any_req;
  logic          w_timeout;
  logic          w_finish;
  logic          w_gap_end;

  // r_last names the requester granted most recently; on a tie the other one wins.
  assign w_pick1   = req1 & (~req0 | ~r_last);
  assign w_any_req = req0 | req1;
  assign w_finish  = (r_state == S_WAIT) && (eng_done || w_timeout);
  assign w_gap_end = (r_gap_cnt == GW'(GAP - 1));

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_to_cnt;

  always_ff @(posedge clk) begin
    if (rst || r_state != S_WAIT) r_to_cnt <= '0;
    else                          r_to_cnt <= r_to_cnt + TW'(1);
  end

  assign w_timeout = (r_state == S_WAIT) && (r_to_cnt == TW'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_finish) w_next = S_GAP;
      S_GAP:   if (w_gap_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || r_state != S_GAP) r_gap_cnt <= '0;
    else                         r_gap_cnt <= r_gap_cnt + GW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_cmd   <= 16'h0000;
      r_resp  <= 16'h0000;
    end else begin
      r_state <= w_next;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      if (r_state == S_IDLE && w_any_req) begin
        r_gnt0 <= ~w_pick1;
        r_gnt1 <= w_pick1;
        r_last <= w_pick1;
        r_cmd  <= w_pick1 ? cmd1 : cmd0;
      end
      // A real engine completion takes priority over a timeout in the same cycle.
      if (w_finish) begin
        r_resp  <= eng_done ? rd_data : 16'hFFFF;
        r_done0 <= r_gnt0;
        r_done1 <= r_gnt1;
        r_gnt0  <= 1'b0;
        r_gnt1  <= 1'b0;
      end
    end
  end

  assign gnt0        = r_gnt0;
  assign gnt1        = r_gnt1;
  assign done0       = r_done0;
  assign done1       = r_done1;
  assign resp        = r_resp;
  assign cmd         = r_cmd;
  assign wrt         = (r_state == S_ISSUE);
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_arb.sv
// Bench for spi_arb: timestamp-based transaction model checked every cycle, plus directed
// literal checks for the single, alternating, late-request, reset and (optional) timeout cases.
module tb_spi_arb;

  localparam int     GAP     = 4;
  localparam int     TIMEOUT = 16;
  localparam longint INF     = 64'sd1000000000000;

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic [15:0] cmd0, cmd1;
  logic        gnt0, gnt1, done0, done1;
  logic [15:0] resp;
  logic        wrt;
  logic [15:0] cmd;
  logic        eng_done;
  logic [15:0] rd_data;
  logic        busy;
  logic [1:0]  dbg_state;

  spi_arb #(.GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .cmd0(cmd0), .req1(req1), .cmd1(cmd1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .resp(resp), .wrt(wrt), .cmd(cmd),
    .eng_done(eng_done), .rd_data(rd_data), .busy(busy),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  longint cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction model ----------------
  // Each transaction is described by the cycle its grant starts and the cycle its done
  // pulses; every output follows from where the current cycle sits relative to those.
  bit          m_valid = 1'b0;
  bit          m_active;
  int          m_owner;
  int          m_last;
  longint      m_grant, m_done, m_idle_from;
  logic [15:0] m_cmd, m_resp;
  logic [15:0] exp_q[$];

  always @(posedge clk) begin
    if (rst) begin
      m_valid     = 1'b1;
      m_active    = 1'b0;
      m_owner     = 0;
      m_last      = 1;
      m_grant     = INF;
      m_done      = INF;
      m_idle_from = cyc + 1;
      m_cmd       = 16'h0000;
      m_resp      = 16'h0000;
      exp_q.delete();
    end else if (m_valid) begin
      if (!m_active && cyc >= m_idle_from && (req0 || req1)) begin
        if (req0 && req1) m_owner = 1 - m_last;
        else              m_owner = req1 ? 1 : 0;
        m_last   = m_owner;
        m_cmd    = (m_owner == 1) ? cmd1 : cmd0;
        m_grant  = cyc + 1;
        m_done   = INF;
        m_active = 1'b1;
      end else if (m_active && cyc >= m_grant + 1) begin
        if (eng_done) begin
          m_resp = rd_data;
          m_done = cyc + 1;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (cyc - (m_grant + 1) == longint'(TIMEOUT - 1)) begin
          m_resp = 16'hFFFF;
          m_done = cyc + 1;
        end
`endif
        if (m_done != INF) begin
          exp_q.push_back(m_resp);
          m_idle_from = m_done + GAP;
          m_active    = 1'b0;
        end
      end
    end
    cyc = cyc + 1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      bit e_gnt0, e_gnt1, e_done0, e_done1, e_wrt, e_busy;
      e_gnt0  = (m_owner == 0) && cyc >= m_grant && cyc < m_done;
      e_gnt1  = (m_owner == 1) && cyc >= m_grant && cyc < m_done;
      e_done0 = (m_owner == 0) && cyc == m_done;
      e_done1 = (m_owner == 1) && cyc == m_done;
      e_wrt   = (cyc == m_grant);
      e_busy  = cyc >= m_grant && cyc < m_done + GAP;
      check("gnt0", 32'(gnt0), 32'(e_gnt0));
      check("gnt1", 32'(gnt1), 32'(e_gnt1));
      check("done0", 32'(done0), 32'(e_done0));
      check("done1", 32'(done1), 32'(e_done1));
      check("wrt", 32'(wrt), 32'(e_wrt));
      check("busy", 32'(busy), 32'(e_busy));
      check("cmd", 32'(cmd), 32'(m_cmd));
      check("resp", 32'(resp), 32'(m_resp));
      if (gnt0 && gnt1) check("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
      if (done0 || done1) begin
        if (exp_q.size() == 0) check("resp_sb_underflow", 32'(done0 | done1), 32'd0);
        else                   check("resp_sb", 32'(resp), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_eng(input logic [15:0] data);
    eng_done = 1'b1;
    rd_data  = data;
    tick(1);
    eng_done = 1'b0;
  endtask

  int     grant_log[$];
  int     n_done;
  int     countdown;
  longint last_done;

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; cmd0 = '0; cmd1 = '0;
    eng_done = 1'b0; rd_data = '0;
    tick(2);
    check("rst_gnt0", 32'(gnt0), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd", 32'(cmd), 32'h0000);
    check("rst_resp", 32'(resp), 32'h0000);
    rst = 1'b0;
    tick(2);

    // Single A2D transaction, engine answers after 20 WAIT cycles.
    req0 = 1'b1; cmd0 = 16'hC000;
    tick(1);
    check("t1_wrt", 32'(wrt), 32'd1);
    check("t1_gnt0", 32'(gnt0), 32'd1);
    check("t1_cmd", 32'(cmd), 32'hC000);
    tick(1);
    check("t1_wrt_one_cycle", 32'(wrt), 32'd0);
    tick(19);
    pulse_eng(16'h0ABC);
    check("t1_done0", 32'(done0), 32'd1);
    check("t1_resp", 32'(resp), 32'h0ABC);
    check("t1_gnt0_drop", 32'(gnt0), 32'd0);
    req0 = 1'b0;
    tick(3);
    check("t1_busy_in_gap", 32'(busy), 32'd1);
    tick(1);
    check("t1_busy_low", 32'(busy), 32'd0);
    tick(2);

    // req1 arrives while req0 is in WAIT; it must wait out req0's GAP.
    req0 = 1'b1; cmd0 = 16'h1111;
    tick(2);
    req1 = 1'b1; cmd1 = 16'h2222;
    tick(4);
    pulse_eng(16'h5555);
    check("t3_done0", 32'(done0), 32'd1);
    req0 = 1'b0;
    tick(4);
    check("t3_gnt1_held_off", 32'(gnt1), 32'd0);
    tick(1);
    check("t3_gnt1", 32'(gnt1), 32'd1);
    check("t3_cmd", 32'(cmd), 32'h2222);
    tick(1);
    req1 = 1'b0;  // dropped mid-transaction: done1 must still arrive
    tick(2);
    pulse_eng(16'h6666);
    check("t3_done1_after_drop", 32'(done1), 32'd1);
    check("t3_resp", 32'(resp), 32'h6666);
    tick(5);

    // Engine completion while idle is ignored.
    pulse_eng(16'hDEAD);
    check("stray_done_resp", 32'(resp), 32'h6666);
    check("stray_done_busy", 32'(busy), 32'd0);
    tick(2);

    // Reset during WAIT after a req0 grant: no done, then a tie goes to req0 again.
    req0 = 1'b1; cmd0 = 16'h3333;
    tick(4);
    rst = 1'b1;
    tick(1);
    check("t4_gnt0", 32'(gnt0), 32'd0);
    check("t4_done0", 32'(done0), 32'd0);
    check("t4_wrt", 32'(wrt), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_cmd", 32'(cmd), 32'h0000);
    rst = 1'b0;
    req1 = 1'b1; cmd1 = 16'h4444;
    tick(1);
    check("t4_tie_gnt0", 32'(gnt0), 32'd1);
    check("t4_tie_cmd", 32'(cmd), 32'h3333);
    tick(2);
    pulse_eng(16'h7777);
    check("t4_done0", 32'(done0), 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    tick(6);

    // Both requests high from reset: grants alternate 0,1,0,1.
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; cmd0 = 16'h0A0A; cmd1 = 16'h1B1B;
    tick(1);
    rst = 1'b0;
    n_done = 0; countdown = 0; last_done = 0;
    for (int i = 0; i < 300 && n_done < 4; i++) begin
      @(negedge clk);
      eng_done = 1'b0;
      if (wrt) begin
        grant_log.push_back(int'(gnt1));
        if (n_done > 0) check("t2_grant_spacing", 32'(cyc - last_done), 32'd5);
        countdown = 3;
      end else if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          eng_done = 1'b1;
          rd_data  = 16'hB000 + 16'(n_done);
        end
      end
      if (done0 || done1) begin
        n_done++;
        last_done = cyc;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("t2_done_count", 32'(n_done), 32'd4);
    for (int k = 0; k < grant_log.size() && k < 4; k++)
      check("t2_grant_order", 32'(grant_log[k]), 32'(k % 2));
    tick(6);

`ifdef SPI_ARB_TIMEOUT_EN
    // Engine never answers: done1 with 16'hFFFF after TIMEOUT cycles of WAIT.
    req1 = 1'b1; cmd1 = 16'hA5A5;
    tick(2);
    tick(15);
    check("to_no_done_yet", 32'(done1), 32'd0);
    tick(1);
    check("to_done1", 32'(done1), 32'd1);
    check("to_resp", 32'(resp), 32'hFFFF);
    req1 = 1'b0;
    tick(3);
    check("to_busy_in_gap", 32'(busy), 32'd1);
    tick(1);
    check("to_busy_low", 32'(busy), 32'd0);
    tick(2);
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_arb.md
SPI_ARB -- requirements
Module: spi_arb

Interface
REQ-001 SHALL have parameter GAP, default 4: idle cycles forced between consecutive SPI transactions (minimum SS_n high time).
REQ-002 SHALL have parameter TIMEOUT, default 1024: cycles to wait for engine completion before abort (used only when SPI_ARB_TIMEOUT_EN is defined).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge clocked.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req0, input, 1 bit: A2D requester wants a transaction; level, held until done0.
REQ-006 SHALL have port cmd0, input, 16 bits: A2D command word; stable while req0 is high.
REQ-007 SHALL have port req1, input, 1 bit: inertial requester wants a transaction; level, held until done1.
REQ-008 SHALL have port cmd1, input, 16 bits: inertial command word; stable while req1 is high.
REQ-009 SHALL have ports gnt0 and gnt1, outputs, 1 bit each: requester 0 or 1 currently owns the engine.
REQ-010 SHALL have ports done0 and done1, outputs, 1 bit each: one-cycle completion pulse to the owning requester.
REQ-011 SHALL have port resp, output, 16 bits: read data of the last completed transaction.
REQ-012 SHALL have port wrt, output, 1 bit: one-cycle start pulse to the shared SPI engine.
REQ-013 SHALL have port cmd, output, 16 bits: command word driven to the engine.
REQ-014 SHALL have port eng_done, input, 1 bit: engine completion pulse.
REQ-015 SHALL have port rd_data, input, 16 bits: engine read data, valid when eng_done is high.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 SHALL implement the states IDLE, ISSUE, WAIT and GAP.
REQ-018 IDLE with any request SHALL go to ISSUE on the next edge, registering gnt and latching cmd from the selected requester.
REQ-019 Arbitration SHALL be round-robin: with both requests high, the requester not granted last wins; with one request high, that requester wins.
REQ-020 In ISSUE, wrt SHALL be high for exactly one cycle, one cycle after req is sampled, followed by an unconditional move to WAIT.
REQ-021 In WAIT, eng_done SHALL capture rd_data into resp and pulse done of the owning requester on the next cycle; gnt SHALL drop in that same cycle and the state SHALL move to GAP.
REQ-022 GAP SHALL last exactly GAP cycles using a counter of width ceil(log2(GAP+1)), then return to IDLE; requests are not sampled during GAP.
REQ-023 eng_done outside WAIT SHALL be ignored.
REQ-024 A request dropped mid-transaction SHALL NOT abort the transaction; done still pulses.
REQ-025 gnt0 and gnt1 SHALL never both be high; at most one of done0 and done1 SHALL be high in any cycle.
REQ-026 Requests SHALL be sampled only in IDLE; a req held high after its done counts as a new request.
REQ-027 cmd and resp SHALL hold their values until the next latch.

Reset
REQ-028 rst SHALL force state IDLE, with gnt0, gnt1, done0, done1, wrt and busy at 0 and cmd and resp at 16'h0000.
REQ-029 rst SHALL clear the GAP and timeout counters and set the last-granted pointer to 1, so req0 wins the first tie.
REQ-030 rst asserted mid-transaction SHALL abandon the transaction with no done pulse.

Configuration
REQ-031 With macro SPI_ARB_TIMEOUT_EN defined, a WAIT counter SHALL run; reaching TIMEOUT cycles without eng_done SHALL pulse the owner's done with resp=16'hFFFF, then go to GAP.
REQ-032 Without SPI_ARB_TIMEOUT_EN, WAIT SHALL wait indefinitely and no timeout counter SHALL exist.

Verification
REQ-033 Bench SHALL cover: req0=1, cmd0=16'hC000, eng_done after 20 cycles with rd_data=16'h0ABC -> wrt 1 cycle after req, cmd=16'hC000, done0 one cycle after eng_done, resp=16'h0ABC, busy low 4 cycles later.
REQ-034 Bench SHALL cover: req0 and req1 both high continuously from reset -> grants alternate gnt0, gnt1, gnt0, gnt1, each separated by 4 GAP cycles.
REQ-035 Bench SHALL cover: req1 raised during req0's WAIT -> req1 is granted only after req0's GAP ends; no overlap of gnt0 and gnt1.
REQ-036 Bench SHALL cover: rst pulsed while in WAIT -> all outputs 0 next cycle, no done pulse, and the next tie goes to req0.
REQ-037 Bench SHALL cover, with SPI_ARB_TIMEOUT_EN and TIMEOUT=16: eng_done never arrives -> done pulse 16 cycles into WAIT with resp=16'hFFFF, then normal GAP.
